memory_arbiter: RTL

Two-port arbiter and sequencer for the byte-addressable data memory. It shares the single memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1). Each access runs as a complete transaction: reads use fixed-latency sampling of the synchronous RAM output, and writes use the memory's write/done handshake. Requester handshakes are simple req/ack pulses. The block sits between the core's fetch/LSU logic and the memory wrapper.

---
 rtl/memory_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sequencer sharing one data-memory port.
// Define MEM_ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES write watchdog.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [1:0]  wsize0,
  input  logic [1:0]  wsize1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_CAP, WR_WAIT, RELEASE
  } state_t;

  state_t      state;
  logic        ptr;
  logic        owner;
  logic        win;
  logic [1:0]  elig;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_wsize;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt;
`endif

  // a req seen alongside its own ack belongs to the finished access
  assign elig = {req1 & ~ack1, req0 & ~ack0};

  always_comb begin
    case (elig)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ptr;
    endcase
  end

  assign w_addr  = win ? addr1  : addr0;
  assign w_wdata = win ? wdata1 : wdata0;
  assign w_wsize = win ? wsize1 : wsize0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_write   <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          if (|elig) begin
            owner <= win;
            ptr   <= ~win;
            if (w_addr[1:0] != 2'b00) begin
              ack0 <= ~win;
              err0 <= ~win;
              ack1 <= win;
              err1 <= win;
            end else begin
              mem_address <= w_addr;
              mem_wdata   <= w_wdata;
              if (w_wsize == 2'd0) begin
                state <= RD_WAIT;
              end else begin
                state     <= WR_WAIT;
                mem_write <= w_wsize;
              end
            end
          end
        end
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          if (owner) begin
            rdata1 <= mem_rdata;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= mem_rdata;
            ack0   <= 1'b1;
          end
          state <= IDLE;
        end
        WR_WAIT: begin
          if (mem_done) begin
            mem_write <= '0;
            ack0      <= ~owner;
            ack1      <= owner;
            state     <= RELEASE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wd_cnt == T_LAST) begin
            mem_write <= '0;
            ack0      <= ~owner;
            ack1      <= owner;
            err0      <= ~owner;
            err1      <= owner;
            state     <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          mem_write <= '0;
          if (!mem_done) state <= IDLE;
        end
        default: begin
          mem_write <= '0;
          state     <= RELEASE;
        end
      endcase
    end
  end
endmodule
